// File: rtl/vga_blob_pkg.sv
// Shared types and widths for the VGA blob frame tracker.
package vga_blob_pkg;

  localparam int COORD_W = 10;
  localparam int COUNT_W = 19;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_REPORT  = 2'd3
  } state_t;

  typedef struct packed {
    logic [COUNT_W-1:0] count;
    logic [COORD_W-1:0] min_x;
    logic [COORD_W-1:0] max_x;
    logic [COORD_W-1:0] min_y;
    logic [COORD_W-1:0] max_y;
    logic               short_frame;
  } result_t;

endpackage

// File: rtl/rgb_to_gray_thresh.sv
// Combinational RGB-to-gray conversion, gray = (R + 2G + B) / 4, and blob threshold.
module rgb_to_gray_thresh
  import vga_blob_pkg::*;
#(
  parameter logic [COORD_W-1:0] THRESH = 10'd512
) (
  input  logic [COORD_W-1:0] r,
  input  logic [COORD_W-1:0] g,
  input  logic [COORD_W-1:0] b,
  output logic               blob
);

  logic [11:0]        sum_s;
  logic [COORD_W-1:0] gray_s;

  // 12-bit weighted sum cannot overflow (4 * 1023 = 4092)
  always_comb begin
    sum_s  = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    gray_s = COORD_W'(sum_s >> 2);
    blob   = (gray_s > THRESH);
  end

endmodule

// File: rtl/vga_blob_frame_tracker.sv
// Captures one VGA frame after a VSYNC edge, accumulates blob count and bounding box,
// and hands the result downstream on a valid/ready handshake.
module vga_blob_frame_tracker
  import vga_blob_pkg::*;
#(
  parameter int                 H_ACTIVE = 800,
  parameter int                 V_ACTIVE = 600,
  parameter logic [COORD_W-1:0] THRESH   = 10'd512
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_grayscale_start,
  input  logic               i_vga_vsync,
  input  logic               i_pix_valid,
  input  logic [COORD_W-1:0] i_r,
  input  logic [COORD_W-1:0] i_g,
  input  logic [COORD_W-1:0] i_b,
  input  logic               i_result_ready,
  output logic               o_result_valid,
  output logic [COUNT_W-1:0] o_blob_count,
  output logic [COORD_W-1:0] o_min_x,
  output logic [COORD_W-1:0] o_max_x,
  output logic [COORD_W-1:0] o_min_y,
  output logic [COORD_W-1:0] o_max_y,
  output logic               o_short_frame,
  output logic               o_bin,
  output logic               o_bin_valid,
  output logic               o_busy
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);

  state_t             state_r, state_nxt_s;
  logic               vsync_q_r, vs_rise_s;
  logic               blob_s, hit_s, last_pix_s, acc_en_s;
  logic               clr_s, load_s, short_s;
  logic [COORD_W-1:0] x_r, y_r, x_nxt_s, y_nxt_s;
  logic [COORD_W-1:0] min_x_r, max_x_r, min_y_r, max_y_r;
  logic [COORD_W-1:0] min_x_nxt_s, max_x_nxt_s, min_y_nxt_s, max_y_nxt_s;
  logic [COUNT_W-1:0] cnt_r, cnt_nxt_s;
  result_t            res_r, res_nxt_s;
  logic               result_valid_r, busy_r, bin_r, bin_valid_r;

  rgb_to_gray_thresh #(.THRESH(THRESH)) u_gray (
    .r    (i_r),
    .g    (i_g),
    .b    (i_b),
    .blob (blob_s)
  );

  assign vs_rise_s  = i_vga_vsync & ~vsync_q_r;
  assign last_pix_s = i_pix_valid && (x_r == X_LAST) && (y_r == Y_LAST);
  assign acc_en_s   = (state_r == ST_CAPTURE) && i_pix_valid;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; dropping start outranks frame completion and VSYNC
  always_comb begin
    state_nxt_s = state_r;
    clr_s       = 1'b0;
    load_s      = 1'b0;
    short_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_grayscale_start) begin
          clr_s       = vs_rise_s;
          state_nxt_s = vs_rise_s ? ST_CAPTURE : ST_ARMED;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (!i_grayscale_start) begin
          state_nxt_s = ST_IDLE;
        end else if (vs_rise_s) begin
          clr_s       = 1'b1;
          state_nxt_s = ST_CAPTURE;
        end else begin
          state_nxt_s = ST_ARMED;
        end
      end
      ST_CAPTURE: begin
        if (!i_grayscale_start) begin
          state_nxt_s = ST_IDLE;
        end else if (last_pix_s) begin
          load_s      = 1'b1;
          state_nxt_s = ST_REPORT;
        end else if (vs_rise_s) begin
          load_s      = 1'b1;
          short_s     = 1'b1;
          state_nxt_s = ST_REPORT;
        end else begin
          state_nxt_s = ST_CAPTURE;
        end
      end
      ST_REPORT: begin
        if (i_result_ready) begin
          state_nxt_s = i_grayscale_start ? ST_ARMED : ST_IDLE;
        end else begin
          state_nxt_s = ST_REPORT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Accumulator values including the current pixel, so the closing pixel lands in the result
  always_comb begin
    hit_s       = i_pix_valid & blob_s;
    cnt_nxt_s   = hit_s ? (cnt_r + COUNT_W'(1)) : cnt_r;
    min_x_nxt_s = (hit_s && (x_r < min_x_r)) ? x_r : min_x_r;
    max_x_nxt_s = (hit_s && (x_r > max_x_r)) ? x_r : max_x_r;
    min_y_nxt_s = (hit_s && (y_r < min_y_r)) ? y_r : min_y_r;
    max_y_nxt_s = (hit_s && (y_r > max_y_r)) ? y_r : max_y_r;
    x_nxt_s     = (x_r == X_LAST) ? COORD_W'(0) : (x_r + COORD_W'(1));
    y_nxt_s     = (x_r == X_LAST) ? (y_r + COORD_W'(1)) : y_r;

    res_nxt_s.count       = cnt_nxt_s;
    res_nxt_s.short_frame = short_s;
    if (cnt_nxt_s == COUNT_W'(0)) begin
      res_nxt_s.min_x = COORD_W'(0);
      res_nxt_s.max_x = COORD_W'(0);
      res_nxt_s.min_y = COORD_W'(0);
      res_nxt_s.max_y = COORD_W'(0);
    end else begin
      res_nxt_s.min_x = min_x_nxt_s;
      res_nxt_s.max_x = max_x_nxt_s;
      res_nxt_s.min_y = min_y_nxt_s;
      res_nxt_s.max_y = max_y_nxt_s;
    end
  end

  // Raster position, blob count and bounding box
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_r     <= COORD_W'(0);
      y_r     <= COORD_W'(0);
      cnt_r   <= COUNT_W'(0);
      min_x_r <= {COORD_W{1'b1}};
      max_x_r <= COORD_W'(0);
      min_y_r <= {COORD_W{1'b1}};
      max_y_r <= COORD_W'(0);
    end else if (clr_s) begin
      x_r     <= COORD_W'(0);
      y_r     <= COORD_W'(0);
      cnt_r   <= COUNT_W'(0);
      min_x_r <= {COORD_W{1'b1}};
      max_x_r <= COORD_W'(0);
      min_y_r <= {COORD_W{1'b1}};
      max_y_r <= COORD_W'(0);
    end else if (acc_en_s) begin
      x_r     <= x_nxt_s;
      y_r     <= y_nxt_s;
      cnt_r   <= cnt_nxt_s;
      min_x_r <= min_x_nxt_s;
      max_x_r <= max_x_nxt_s;
      min_y_r <= min_y_nxt_s;
      max_y_r <= max_y_nxt_s;
    end
  end

  // Registered outputs; the result is latched once on REPORT entry and held until the next frame
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vsync_q_r      <= 1'b0;
      result_valid_r <= 1'b0;
      busy_r         <= 1'b0;
      bin_r          <= 1'b0;
      bin_valid_r    <= 1'b0;
      res_r          <= '0;
    end else begin
      vsync_q_r      <= i_vga_vsync;
      result_valid_r <= (state_nxt_s == ST_REPORT);
      busy_r         <= (state_nxt_s == ST_ARMED) || (state_nxt_s == ST_CAPTURE);
      bin_r          <= blob_s;
      bin_valid_r    <= i_pix_valid;
      if (load_s) begin
        res_r <= res_nxt_s;
      end
    end
  end

  assign o_result_valid = result_valid_r;
  assign o_blob_count   = res_r.count;
  assign o_min_x        = res_r.min_x;
  assign o_max_x        = res_r.max_x;
  assign o_min_y        = res_r.min_y;
  assign o_max_y        = res_r.max_y;
  assign o_short_frame  = res_r.short_frame;
  assign o_bin          = bin_r;
  assign o_bin_valid    = bin_valid_r;
  assign o_busy         = busy_r;

endmodule

// File: tb/tb_vga_blob_frame_tracker.sv
// Directed bench for vga_blob_frame_tracker on a 4x3 frame with a frame-level result model.
module tb_vga_blob_frame_tracker;

  localparam int H    = 4;
  localparam int V    = 3;
  localparam int NPIX = H * V;
  localparam int TH   = 512;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_grayscale_start = 1'b0;
  logic        i_vga_vsync = 1'b0;
  logic        i_pix_valid = 1'b0;
  logic [9:0]  i_r = 10'd0, i_g = 10'd0, i_b = 10'd0;
  logic        i_result_ready = 1'b0;
  logic        o_result_valid;
  logic [18:0] o_blob_count;
  logic [9:0]  o_min_x, o_max_x, o_min_y, o_max_y;
  logic        o_short_frame, o_bin, o_bin_valid, o_busy;

  always #5 i_clk = ~i_clk;

  vga_blob_frame_tracker #(.H_ACTIVE(H), .V_ACTIVE(V), .THRESH(10'd512)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_grayscale_start(i_grayscale_start),
    .i_vga_vsync(i_vga_vsync), .i_pix_valid(i_pix_valid),
    .i_r(i_r), .i_g(i_g), .i_b(i_b), .i_result_ready(i_result_ready),
    .o_result_valid(o_result_valid), .o_blob_count(o_blob_count),
    .o_min_x(o_min_x), .o_max_x(o_max_x), .o_min_y(o_min_y), .o_max_y(o_max_y),
    .o_short_frame(o_short_frame), .o_bin(o_bin), .o_bin_valid(o_bin_valid), .o_busy(o_busy)
  );

  typedef struct {
    int count;
    int min_x;
    int max_x;
    int min_y;
    int max_y;
    int short_f;
  } exp_t;

  exp_t exp_q[$];
  int   fr_r[NPIX], fr_g[NPIX], fr_b[NPIX];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int gray_of(input int r, input int g, input int b);
    return (r + 2 * g + b) / 4;
  endfunction

  // Frame result from the first n pixels of the current frame buffer, raster order
  function automatic exp_t model_frame(input int n, input int short_f);
    exp_t e;
    e.count = 0; e.min_x = 1 << 30; e.max_x = -1; e.min_y = 1 << 30; e.max_y = -1;
    e.short_f = short_f;
    for (int i = 0; i < n; i++) begin
      if (gray_of(fr_r[i], fr_g[i], fr_b[i]) > TH) begin
        e.count++;
        if (i % H < e.min_x) e.min_x = i % H;
        if (i % H > e.max_x) e.max_x = i % H;
        if (i / H < e.min_y) e.min_y = i / H;
        if (i / H > e.max_y) e.max_y = i / H;
      end
    end
    if (e.count == 0) begin
      e.min_x = 0; e.max_x = 0; e.min_y = 0; e.max_y = 0;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < NPIX; i++) begin
      fr_r[i] = v; fr_g[i] = v; fr_b[i] = v;
    end
  endtask

  task automatic set_pix(input int i, input int v);
    fr_r[i] = v; fr_g[i] = v; fr_b[i] = v;
  endtask

  task automatic send(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      i_pix_valid = 1'b1;
      i_r = 10'(fr_r[i]); i_g = 10'(fr_g[i]); i_b = 10'(fr_b[i]);
      tick();
    end
    i_pix_valid = 1'b0;
  endtask

  task automatic vsync_pulse();
    i_vga_vsync = 1'b1;
    tick();
    i_vga_vsync = 1'b0;
    tick();
  endtask

  task automatic accept();
    i_result_ready = 1'b1;
    tick();
    i_result_ready = 1'b0;
  endtask

  task automatic check_result(input string name, input int cnt, input int mnx, input int mxx,
                              input int mny, input int mxy, input int sh);
    check({name, "_valid"}, o_result_valid, 1);
    check({name, "_count"}, o_blob_count, cnt);
    check({name, "_min_x"}, o_min_x, mnx);
    check({name, "_max_x"}, o_max_x, mxx);
    check({name, "_min_y"}, o_min_y, mny);
    check({name, "_max_y"}, o_max_y, mxy);
    check({name, "_short"}, o_short_frame, sh);
  endtask

  // Per-cycle compare against the model: display path, queued frame results, handshake drop
  initial begin : compare
    bit   skip = 1'b1;
    bit   was_valid = 1'b0;
    bit   was_hs = 1'b0;
    bit   have_cur = 1'b0;
    int   prev_pv = 0;
    int   prev_blob = 0;
    exp_t cur;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        skip = 1'b1; was_valid = 1'b0; was_hs = 1'b0;
      end else if (skip) begin
        skip = 1'b0;
      end else begin
        check("bin_valid", o_bin_valid, prev_pv);
        check("bin", o_bin, prev_blob);
        if (was_hs) check("valid_drop_after_accept", o_result_valid, 0);
        if (o_result_valid) begin
          if (!was_valid) begin
            have_cur = (exp_q.size() > 0);
            if (have_cur) cur = exp_q.pop_front();
            else check("unexpected_result", 1, 0);
          end
          if (have_cur) begin
            check("m_count", o_blob_count, cur.count);
            check("m_min_x", o_min_x, cur.min_x);
            check("m_max_x", o_max_x, cur.max_x);
            check("m_min_y", o_min_y, cur.min_y);
            check("m_max_y", o_max_y, cur.max_y);
            check("m_short", o_short_frame, cur.short_f);
          end
        end
        was_valid = o_result_valid;
        was_hs    = o_result_valid && i_result_ready;
      end
      prev_pv   = int'(i_pix_valid);
      prev_blob = (gray_of(int'(i_r), int'(i_g), int'(i_b)) > TH) ? 1 : 0;
    end
  end

  initial begin : stimulus
    repeat (3) tick();
    check("rst_valid", o_result_valid, 0);
    check("rst_count", o_blob_count, 0);
    check("rst_min_x", o_min_x, 0);
    check("rst_busy", o_busy, 0);
    check("rst_bin_valid", o_bin_valid, 0);
    i_rst_n = 1'b1;
    tick();

    // Full frame of saturated pixels; result one cycle after the last pixel
    i_grayscale_start = 1'b1;
    tick();
    check("armed_busy", o_busy, 1);
    fill(1023);
    exp_q.push_back(model_frame(NPIX, 0));
    vsync_pulse();
    send(0, NPIX - 1);
    check("t1_not_early", o_result_valid, 0);
    send(NPIX - 1, 1);
    check_result("t1", 12, 0, 3, 0, 2, 0);
    accept();
    check("t1_dropped", o_result_valid, 0);

    // Single blob pixel at (2,1)
    fill(0);
    set_pix(6, 1023);
    exp_q.push_back(model_frame(NPIX, 0));
    vsync_pulse();
    send(0, NPIX);
    check_result("t2", 1, 2, 2, 1, 1, 0);
    accept();

    // Gray exactly at threshold is not a blob
    fill(512);
    exp_q.push_back(model_frame(NPIX, 0));
    vsync_pulse();
    send(0, NPIX);
    check_result("t3", 0, 0, 0, 0, 0, 0);
    accept();

    // Short frame: VSYNC after 5 blob pixels
    fill(1023);
    exp_q.push_back(model_frame(5, 1));
    vsync_pulse();
    send(0, 5);
    i_vga_vsync = 1'b1;
    tick();
    check_result("t4", 5, 0, 3, 0, 1, 1);

    // Back-pressure with VSYNC edges during REPORT; that frame is skipped
    for (int k = 0; k < 5; k++) begin
      i_vga_vsync = 1'b0;
      tick();
      i_vga_vsync = 1'b1;
      tick();
    end
    i_vga_vsync = 1'b0;
    check_result("t5_held", 5, 0, 3, 0, 1, 1);
    accept();
    send(0, NPIX);
    check("t5_skipped_frame", o_result_valid, 0);
    check("t5_still_armed", o_busy, 1);

    // Next frame; last pixel coincides with VSYNC and ready is already high
    fill(0);
    set_pix(1, 1023);
    set_pix(11, 1023);
    exp_q.push_back(model_frame(NPIX, 0));
    vsync_pulse();
    i_result_ready = 1'b1;
    send(0, NPIX - 1);
    i_vga_vsync = 1'b1;
    send(NPIX - 1, 1);
    check_result("t5", 2, 1, 3, 0, 2, 0);
    i_vga_vsync = 1'b0;
    tick();
    i_result_ready = 1'b0;
    check("t5_one_cycle", o_result_valid, 0);

    // start dropped mid-capture discards the frame
    vsync_pulse();
    send(0, 6);
    i_grayscale_start = 1'b0;
    tick();
    check("t6_idle_busy", o_busy, 0);
    send(6, 6);
    check("t6_no_result", o_result_valid, 0);

    // Async reset while a result is pending
    i_grayscale_start = 1'b1;
    tick();
    fill(1023);
    exp_q.push_back(model_frame(NPIX, 0));
    vsync_pulse();
    send(0, NPIX);
    check_result("t6", 12, 0, 3, 0, 2, 0);
    @(negedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    check("arst_valid", o_result_valid, 0);
    check("arst_count", o_blob_count, 0);
    check("arst_max_x", o_max_x, 0);
    check("arst_max_y", o_max_y, 0);
    check("arst_busy", o_busy, 0);
    check("arst_bin", o_bin, 0);
    check("arst_bin_valid", o_bin_valid, 0);
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();
    tick();
    check("no_result_after_reset", o_result_valid, 0);
    check("results_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
